// File: rtl/amstrad_io_pkg.sv
// Constants shared by the boot download and upload read paths: ROM page bases,
// ioctl file indices and the upload engine state encoding.
package amstrad_io_pkg;

    localparam logic [8:0] ROM_OS_ADDR     = 9'h000;
    localparam logic [8:0] ROM_BASIC_ADDR  = 9'h100;
    localparam logic [8:0] ROM_AMSDOS_ADDR = 9'h107;
    localparam logic [8:0] ROM_MF2_ADDR    = 9'h0FF;

    localparam logic [7:0] IDX_ROM  = 8'd0;
    localparam logic [7:0] IDX_TAPE = 8'd4;
    localparam logic [7:0] IDX_CPR  = 8'd5;
    localparam logic [7:0] IDX_BIN  = 8'd6;

    localparam int IOCTL_ADDR_W = 25;
    localparam int SD_ADDR_W    = 23;

    typedef enum logic [1:0] {
        UPL_IDLE  = 2'd0,
        UPL_FETCH = 2'd1,
        UPL_DONE  = 2'd2
    } upload_state_e;

    // Returns {unmapped, page_base} for a 16 KB block of the index-0 ROM file.
    function automatic logic [9:0] rom_block_lookup(input logic [10:0] blk);
        logic [9:0] r;
        case (blk)
            11'd0:   r = {1'b0, ROM_OS_ADDR};
            11'd1:   r = {1'b0, ROM_BASIC_ADDR};
            11'd2:   r = {1'b0, ROM_AMSDOS_ADDR};
            11'd3:   r = {1'b0, ROM_MF2_ADDR};
            default: r = {1'b1, 9'h000};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// Bundle of the HPS ioctl read side, the SDRAM read port and the status/debug
// outputs of the upload reader. slave = engine view, master = host/memory view.
interface ioctl_upload_reader_if;

    // Handshakes: ioctl_rd is a one-cycle strobe that starts a byte; ioctl_wait stays
    // high until ioctl_din is valid. rd_req is a level held with rd_addr/rd_bank stable
    // until the one-cycle rd_ack pulse, and rd_data is only valid in the rd_ack cycle.
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_index;
    logic [8:0]  page;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    logic        rd_req;
    logic [22:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        rd_ack;
    logic [7:0]  rd_data;

    logic        busy;
    logic [24:0] byte_count;
    logic        timeout_err;
    logic        overrun_err;
    logic [1:0]  dbg_state;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, page, rd_ack, rd_data,
        output ioctl_din, ioctl_wait, rd_req, rd_addr, rd_bank,
        output busy, byte_count, timeout_err, overrun_err, dbg_state
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, page, rd_ack, rd_data,
        input  ioctl_din, ioctl_wait, rd_req, rd_addr, rd_bank,
        input  busy, byte_count, timeout_err, overrun_err, dbg_state
    );

endinterface

// File: rtl/upload_addr_map.sv
// Combinational file-address to SDRAM-address map; the inverse of the boot
// download placement, so both paths agree on where each file byte lives.
module upload_addr_map
    import amstrad_io_pkg::*;
(
    input  logic [24:0] i_addr,
    input  logic [7:0]  i_index,
    input  logic [8:0]  i_page,
    output logic [22:0] o_sd_addr,
    output logic [1:0]  o_bank,
    output logic        o_unmapped
);

    logic [9:0] w_rom;
    logic [8:0] w_hi;

    always_comb begin
        w_rom      = rom_block_lookup(i_addr[24:14]);
        w_hi       = 9'h000;
        o_bank     = 2'b00;
        o_unmapped = 1'b0;
        if (i_index == IDX_ROM) begin
            w_hi       = w_rom[8:0];
            o_unmapped = w_rom[9];
        end else if (i_index == IDX_CPR || i_index == IDX_BIN) begin
            w_hi = {1'b1, i_addr[21:14]};
        end else begin
            // Page offset wraps inside 8 bits; page[8] picks the upper half of the bank.
            w_hi   = {i_page[8], i_page[7:0] + i_addr[21:14]};
            o_bank = {1'b0, &i_index[7:6]};
        end
    end

    assign o_sd_addr = {w_hi, i_addr[13:0]};

endmodule

// File: rtl/ioctl_upload_reader.sv
// HPS upload read engine: maps each ioctl_rd byte into SDRAM, fetches it over the
// req/ack port and holds ioctl_wait until ioctl_din is valid.
module ioctl_upload_reader
    import amstrad_io_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] FILL_BYTE      = 8'hFF
)(
    input  logic                  clk_48,
    input  logic                  reset,
    ioctl_upload_reader_if.slave  bus
);

    localparam logic [1:0]  S_IDLE     = UPL_IDLE;
    localparam logic [1:0]  S_FETCH    = UPL_FETCH;
    localparam logic [1:0]  S_DONE     = UPL_DONE;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_din;
    logic        r_wait;
    logic        r_rd_req;
    logic [22:0] r_rd_addr;
    logic [1:0]  r_rd_bank;
    logic        r_unmapped;
    logic [24:0] r_byte_count;
    logic        r_timeout_err;
    logic        r_overrun_err;
    logic        r_upload_d;

    logic [22:0] w_map_addr;
    logic [1:0]  w_map_bank;
    logic        w_map_unmapped;
    logic        w_upload_rise;
    logic        w_busy;

    upload_addr_map u_map (
        .i_addr     (bus.ioctl_addr),
        .i_index    (bus.ioctl_index),
        .i_page     (bus.page),
        .o_sd_addr  (w_map_addr),
        .o_bank     (w_map_bank),
        .o_unmapped (w_map_unmapped)
    );

    assign w_upload_rise = bus.ioctl_upload & ~r_upload_d;
    assign w_busy        = (r_state != S_IDLE);

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_timer       <= 16'h0000;
            r_din         <= 8'h00;
            r_wait        <= 1'b0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= 23'h000000;
            r_rd_bank     <= 2'b00;
            r_unmapped    <= 1'b0;
            r_byte_count  <= 25'h0000000;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
            r_upload_d    <= 1'b0;
        end else begin
            r_upload_d <= bus.ioctl_upload;

            if (w_upload_rise) begin
                r_byte_count  <= 25'h0000000;
                r_timeout_err <= 1'b0;
                r_overrun_err <= 1'b0;
            end
            if (bus.ioctl_rd && w_busy) begin
                r_overrun_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.ioctl_rd && bus.ioctl_upload) begin
                        r_rd_addr  <= w_map_addr;
                        r_rd_bank  <= w_map_bank;
                        r_unmapped <= w_map_unmapped;
                        r_rd_req   <= ~w_map_unmapped;
                        r_wait     <= 1'b1;
                        r_timer    <= 16'h0000;
                        r_state    <= S_FETCH;
                    end
                end

                // Unmapped bytes pass through FETCH for one cycle without a request,
                // giving them the same ack-edge + DONE shape as a zero-latency fetch.
                S_FETCH: begin
                    if (!bus.ioctl_upload) begin
                        r_rd_req <= 1'b0;
                        r_wait   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_unmapped) begin
                        r_din   <= FILL_BYTE;
                        r_state <= S_DONE;
                    end else if (bus.rd_ack) begin
                        r_din    <= bus.rd_data;
                        r_rd_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_din         <= FILL_BYTE;
                        r_timeout_err <= 1'b1;
                        r_rd_req      <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 16'h0001;
                    end
                end

                S_DONE: begin
                    r_wait  <= 1'b0;
                    r_state <= S_IDLE;
                    if (bus.ioctl_upload) begin
                        r_byte_count <= r_byte_count + 25'h0000001;
                    end
                end

                default: begin
                    r_rd_req <= 1'b0;
                    r_wait   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ioctl_din   = r_din;
    assign bus.ioctl_wait  = r_wait;
    assign bus.rd_req      = r_rd_req;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.rd_bank     = r_rd_bank;
    assign bus.busy        = w_busy;
    assign bus.byte_count  = r_byte_count;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun_err = r_overrun_err;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: table of mapped/unmapped reads, random Plus reads,
// and hand sequences for timeout, overrun, abort and asynchronous reset.
`timescale 1ns/1ps
module tb_ioctl_upload_reader;

    logic clk_48 = 1'b0;
    logic reset;
    always #5 clk_48 = ~clk_48;

    ioctl_upload_reader_if u_if ();

    ioctl_upload_reader #(
        .TIMEOUT_CYCLES (255),
        .FILL_BYTE      (8'hFF)
    ) dut (
        .clk_48 (clk_48),
        .reset  (reset),
        .bus    (u_if)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [8:0]  page;
        int          ack_delay;   // req cycles before the ack cycle; -1 = never ack
        logic [7:0]  rdata;
        logic        unmapped;
        logic [22:0] exp_addr;
        logic [1:0]  exp_bank;
        logic [7:0]  exp_din;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [24:0] exp_count = '0;
    logic [7:0]  last_din = 8'h00;
    vec_t        vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_read(input logic [7:0] idx, input logic [24:0] addr, input logic [8:0] page);
        @(negedge clk_48);
        u_if.ioctl_index = idx;
        u_if.ioctl_addr  = addr;
        u_if.page        = page;
        u_if.ioctl_rd    = 1'b1;
        @(negedge clk_48);
        u_if.ioctl_rd = 1'b0;
    endtask

    task automatic do_read(input string tag, input vec_t v);
        int waits, reqs, guard, exp_reqs, exp_waits;
        bit addr_bad;
        exp_q.push_back(v.exp_din);
        start_read(v.idx, v.addr, v.page);
        waits = 0; reqs = 0; guard = 0; addr_bad = 0;
        while (u_if.ioctl_wait === 1'b1 && guard < 400) begin
            waits++;
            if (u_if.rd_req === 1'b1) begin
                reqs++;
                if (u_if.rd_addr !== v.exp_addr || u_if.rd_bank !== v.exp_bank) addr_bad = 1;
                if (v.ack_delay >= 0 && reqs == v.ack_delay + 1) begin
                    u_if.rd_ack  = 1'b1;
                    u_if.rd_data = v.rdata;
                end
            end
            @(negedge clk_48);
            u_if.rd_ack  = 1'b0;
            u_if.rd_data = 8'($urandom_range(0, 255));
            guard++;
        end
        if (v.unmapped) begin
            exp_reqs = 0;  exp_waits = 2;
        end else if (v.ack_delay < 0) begin
            exp_reqs = 255; exp_waits = 256;
        end else begin
            exp_reqs = v.ack_delay + 1; exp_waits = v.ack_delay + 2;
        end
        check({tag, " wait_bound"}, guard < 400, 1);
        check({tag, " wait_cycles"}, waits, exp_waits);
        check({tag, " req_cycles"}, reqs, exp_reqs);
        if (!v.unmapped) check({tag, " rd_addr_bank"}, addr_bad, 0);
        exp_count = exp_count + 25'd1;
        last_din  = exp_q.pop_front();
        check({tag, " ioctl_din"}, u_if.ioctl_din, last_din);
        check({tag, " byte_count"}, u_if.byte_count, exp_count);
        check({tag, " busy_after"}, u_if.busy, 0);
    endtask

    task automatic upload_restart();
        @(negedge clk_48);
        u_if.ioctl_upload = 1'b0;
        @(negedge clk_48);
        u_if.ioctl_upload = 1'b1;
        @(negedge clk_48);
        exp_count = '0;
    endtask

    initial begin
        vec_t rv;
        int   rises;
        logic prev_req;

        //          idx    addr          page    dly  data   unm   exp_addr      bank   din
        vecs[0]  = '{8'h00, 25'h0004005, 9'h000, 3,   8'h5A, 1'b0, 23'h400005, 2'b00, 8'h5A};
        vecs[1]  = '{8'h00, 25'h0010000, 9'h000, 0,   8'h00, 1'b1, 23'h000000, 2'b00, 8'hFF};
        vecs[2]  = '{8'h05, 25'h000C123, 9'h000, 1,   8'h3C, 1'b0, 23'h40C123, 2'b00, 8'h3C};
        vecs[3]  = '{8'hC1, 25'h0004000, 9'h1FF, 0,   8'hA7, 1'b0, 23'h400000, 2'b01, 8'hA7};
        vecs[4]  = '{8'h00, 25'h000C00A, 9'h000, 2,   8'h11, 1'b0, 23'h3FC00A, 2'b00, 8'h11};
        vecs[5]  = '{8'h00, 25'h0008001, 9'h000, 5,   8'h99, 1'b0, 23'h41C001, 2'b00, 8'h99};
        vecs[6]  = '{8'h06, 25'h1FFFFFF, 9'h000, 1,   8'h42, 1'b0, 23'h7FFFFF, 2'b00, 8'h42};
        vecs[7]  = '{8'h04, 25'h000BABE, 9'h023, 4,   8'hC3, 1'b0, 23'h097ABE, 2'b00, 8'hC3};
        vecs[8]  = '{8'h00, 25'h0000123, 9'h000, 0,   8'h01, 1'b0, 23'h000123, 2'b00, 8'h01};
        vecs[9]  = '{8'h00, 25'h1FFC000, 9'h000, 0,   8'h00, 1'b1, 23'h000000, 2'b00, 8'hFF};
        vecs[10] = '{8'h80, 25'h0007FFF, 9'h100, 2,   8'h77, 1'b0, 23'h407FFF, 2'b00, 8'h77};

        reset = 1'b1;
        u_if.ioctl_upload = 1'b0; u_if.ioctl_rd = 1'b0; u_if.ioctl_addr = '0;
        u_if.ioctl_index = '0; u_if.page = '0; u_if.rd_ack = 1'b0; u_if.rd_data = '0;
        repeat (3) @(negedge clk_48);
        check("reset din", u_if.ioctl_din, 8'h00);
        check("reset wait_req_busy", {u_if.ioctl_wait, u_if.rd_req, u_if.busy}, 3'b000);
        check("reset rd_addr_bank", {u_if.rd_addr, u_if.rd_bank}, 25'h0);
        check("reset count_errs", {u_if.byte_count, u_if.timeout_err, u_if.overrun_err}, 27'h0);
        check("reset state", u_if.dbg_state, 2'd0);
        reset = 1'b0;
        u_if.ioctl_upload = 1'b1;
        @(negedge clk_48);

        for (int i = 0; i < 11; i++) do_read($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.idx       = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06;
            rv.addr      = 25'($urandom_range(0, 32'h01FF_FFFF));
            rv.page      = 9'($urandom_range(0, 511));
            rv.ack_delay = $urandom_range(0, 6);
            rv.rdata     = 8'($urandom_range(0, 255));
            rv.unmapped  = 1'b0;
            rv.exp_addr  = {1'b1, rv.addr[21:14], rv.addr[13:0]};
            rv.exp_bank  = 2'b00;
            rv.exp_din   = rv.rdata;
            do_read($sformatf("rand%0d", i), rv);
        end

        // Read strobe with upload low and a stray ack in IDLE are both ignored.
        u_if.ioctl_upload = 1'b0;
        start_read(8'h05, 25'h0000001, 9'h000);
        check("rd_no_upload wait_req", {u_if.ioctl_wait, u_if.rd_req, u_if.busy}, 3'b000);
        u_if.ioctl_upload = 1'b1;
        u_if.rd_ack = 1'b1; u_if.rd_data = 8'hEE;
        @(negedge clk_48);
        u_if.rd_ack = 1'b0;
        @(negedge clk_48);
        exp_count = '0;
        check("idle_ack din", u_if.ioctl_din, last_din);
        check("upload_rise count", u_if.byte_count, 0);

        // Timeout, then the ack landing on the final timeout cycle.
        rv = '{8'h05, 25'h0000200, 9'h000, -1, 8'h00, 1'b0, 23'h400200, 2'b00, 8'hFF};
        do_read("timeout", rv);
        check("timeout_err set", u_if.timeout_err, 1);
        upload_restart();
        check("timeout_err cleared", u_if.timeout_err, 0);
        check("restart count", u_if.byte_count, 0);
        rv = '{8'h06, 25'h0000300, 9'h000, 254, 8'hB4, 1'b0, 23'h400300, 2'b00, 8'hB4};
        do_read("ack_at_limit", rv);
        check("ack_at_limit no_err", u_if.timeout_err, 0);

        // Second strobe mid-FETCH: flagged, ignored, only one request.
        exp_q.push_back(8'h6D);
        start_read(8'h05, 25'h0001234, 9'h000);
        rises = 0; prev_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (u_if.rd_req === 1'b1 && !prev_req) rises++;
            prev_req = u_if.rd_req;
            u_if.ioctl_rd = (c == 2);
            if (c == 2) u_if.ioctl_addr = 25'h0008000;
            u_if.rd_ack  = (c == 4);
            u_if.rd_data = 8'h6D;
            @(negedge clk_48);
        end
        u_if.rd_ack = 1'b0;
        exp_count = exp_count + 25'd1;
        last_din  = exp_q.pop_front();
        check("overrun req_rises", rises, 1);
        check("overrun_err set", u_if.overrun_err, 1);
        check("overrun din", u_if.ioctl_din, last_din);
        check("overrun count", u_if.byte_count, exp_count);

        // Upload drops mid-FETCH: abort next edge, count untouched.
        start_read(8'h05, 25'h0000010, 9'h000);
        @(negedge clk_48);
        check("abort pre_req", u_if.rd_req, 1);
        u_if.ioctl_upload = 1'b0;
        @(negedge clk_48);
        check("abort req_wait_busy", {u_if.rd_req, u_if.ioctl_wait, u_if.busy}, 3'b000);
        check("abort count", u_if.byte_count, exp_count);
        check("abort din", u_if.ioctl_din, last_din);
        u_if.ioctl_upload = 1'b1;
        @(negedge clk_48);
        @(negedge clk_48);
        exp_count = '0;
        check("abort restart overrun", u_if.overrun_err, 0);

        // Asynchronous reset in the middle of a fetch.
        do_read("pre_reset", vecs[2]);
        start_read(8'h05, 25'h0000400, 9'h000);
        @(negedge clk_48);
        reset = 1'b1;
        #1;
        check("async din", u_if.ioctl_din, 8'h00);
        check("async wait_req_busy", {u_if.ioctl_wait, u_if.rd_req, u_if.busy}, 3'b000);
        check("async rd_addr_bank", {u_if.rd_addr, u_if.rd_bank}, 25'h0);
        check("async count_errs", {u_if.byte_count, u_if.timeout_err, u_if.overrun_err}, 27'h0);
        @(negedge clk_48);
        reset = 1'b0;
        exp_count = '0;
        @(negedge clk_48);
        do_read("post_reset", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
